mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mips_arb_pkg.sv | 20 ++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mips_arb_pkg.sv
// Shared types and widths for the instruction/data memory port arbiter.
package mips_arb_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  // Arbiter FSM encoding; also driven out on dbg_state.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  // Which requester owns the transaction in flight.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory with
// fixed read latency. One transaction is in flight at a time.
//
// Handshake: a requester raises req with stable addr/we/wdata and holds them
// until it sees a one-cycle ack; stall = req & ~ack. A new request may start
// no earlier than the cycle after the ack. Each transaction occupies the
// memory for LATENCY+2 cycles after the grant cycle.
module mem_port_arbiter
  import mips_arb_pkg::*;
#(
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ip_if_req,
  input  logic [ADDR_W-1:0] ip_if_addr,
  output logic [DATA_W-1:0] op_if_rdata,
  output logic              op_if_ack,
  output logic              op_if_stall,
  input  logic              ip_dm_req,
  input  logic              ip_dm_we,
  input  logic [ADDR_W-1:0] ip_dm_addr,
  input  logic [DATA_W-1:0] ip_dm_wdata,
  output logic [DATA_W-1:0] op_dm_rdata,
  output logic              op_dm_ack,
  output logic              op_dm_stall,
  output logic              op_mem_en,
  output logic              op_mem_we,
  output logic [ADDR_W-1:0] op_mem_addr,
  output logic [DATA_W-1:0] op_mem_wdata,
  input  logic [DATA_W-1:0] ip_mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam logic [3:0] LAT4    = 4'(LATENCY);
  localparam logic [3:0] STARVE4 = 4'(STARVE_LIMIT);

  arb_state_e        state;
  arb_owner_e        owner;
  logic [3:0]        lat_cnt;
  logic [3:0]        starve_cnt;
  logic              wr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              if_ack_q;
  logic              dm_ack_q;
  logic              any_req;
  logic              pick_if;

  // Owner selection: data has priority unless fetch has waited STARVE_LIMIT grants.
  always_comb begin
    any_req = ip_if_req | ip_dm_req;
    pick_if = ip_if_req & (~ip_dm_req | (starve_cnt == STARVE4));
  end

  // FSM, memory command registers, latency and starvation counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      owner        <= OWN_IF;
      lat_cnt      <= '0;
      starve_cnt   <= '0;
      wr_q         <= 1'b0;
      rdata_q      <= '0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      op_mem_en    <= 1'b0;
      op_mem_we    <= 1'b0;
      op_mem_addr  <= '0;
      op_mem_wdata <= '0;
    end else begin
      // Command and acks are single-cycle pulses; idle value is all zeros.
      op_mem_en    <= 1'b0;
      op_mem_we    <= 1'b0;
      op_mem_addr  <= '0;
      op_mem_wdata <= '0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          rdata_q <= '0;
          if (any_req) begin
            state     <= ST_ACCESS;
            lat_cnt   <= LAT4;
            op_mem_en <= 1'b1;
            if (pick_if) begin
              owner       <= OWN_IF;
              wr_q        <= 1'b0;
              op_mem_addr <= ip_if_addr;
              starve_cnt  <= '0;
            end else begin
              owner        <= OWN_DM;
              wr_q         <= ip_dm_we;
              op_mem_we    <= ip_dm_we;
              op_mem_addr  <= ip_dm_addr;
              op_mem_wdata <= ip_dm_wdata;
              if (ip_if_req && (starve_cnt != STARVE4)) begin
                starve_cnt <= starve_cnt + 4'd1;
              end
            end
          end
        end
        ST_ACCESS: begin
          if (lat_cnt == 4'd0) begin
            // Read data is valid now; writes report zero.
            rdata_q <= wr_q ? '0 : ip_mem_rdata;
            state   <= ST_RESP;
            if (owner == OWN_IF) begin
              if_ack_q <= 1'b1;
            end else begin
              dm_ack_q <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          rdata_q <= '0;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Ack-qualified read data and requester stalls.
  always_comb begin
    op_if_ack   = if_ack_q;
    op_dm_ack   = dm_ack_q;
    op_if_rdata = if_ack_q ? rdata_q : '0;
    op_dm_rdata = dm_ack_q ? rdata_q : '0;
    op_if_stall = ip_if_req & ~if_ack_q;
    op_dm_stall = ip_dm_req & ~dm_ack_q;
    dbg_state   = state;
  end

endmodule
